// File: rtl/sos_cascade_sequencer.sv
// Sequencer for a time-multiplexed biquad cascade: accepts one sample, runs it through
// No_SOS passes of the shared datapath with saturation, then hands the result downstream.
module sos_cascade_sequencer #(
    parameter int unsigned BW     = 9,
    parameter int unsigned No_SOS = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic signed [BW-1:0] x_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [BW-1:0] stage_in,
    output logic [3:0]           stage_idx,
    output logic                 stage_en,
    input  logic signed [BW+1:0] stage_out,
    output logic signed [BW-1:0] y_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sat_flag
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic signed [BW-1:0] SatMax  = {1'b0, {(BW-1){1'b1}}};
    localparam logic signed [BW-1:0] SatMin  = {1'b1, {(BW-1){1'b0}}};
    localparam logic [3:0]           LastIdx = 4'(No_SOS - 1);

    state_e               state_q, state_d;
    logic signed [BW-1:0] acc_q, acc_d;
    logic [3:0]           idx_q, idx_d;
    logic                 sat_q, sat_d;

    logic [2:0]           top_bits;
    logic                 in_range;
    logic                 overflow;
    logic signed [BW-1:0] sat_val;

    // Result fits in BW bits exactly when the top three bits are a pure sign extension.
    assign top_bits = stage_out[BW+1:BW-1];
    assign in_range = (&top_bits) | ~(|top_bits);
    assign overflow = ~in_range;

    always_comb begin
        sat_val = stage_out[BW-1:0];
        if (!in_range) begin
            sat_val = stage_out[BW+1] ? SatMin : SatMax;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        sat_d   = sat_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    acc_d   = x_in;
                    idx_d   = 4'd0;
                    sat_d   = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = sat_val;
                sat_d = sat_q | overflow;
                if (idx_q == LastIdx) begin
                    idx_d   = 4'd0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= StIdle;
            acc_q   <= '0;
            idx_q   <= 4'd0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            sat_q   <= sat_d;
        end
    end

    assign stage_in  = acc_q;
    assign y_out     = acc_q;
    assign stage_idx = idx_q;
    assign sat_flag  = sat_q;
    assign in_ready  = (state_q == StIdle);
    assign stage_en  = (state_q == StRun);
    assign out_valid = (state_q == StDone);

endmodule

// File: tb/tb_sos_cascade_sequencer.sv
// Randomized self-checking bench for sos_cascade_sequencer against an arithmetic cascade model.
module tb_sos_cascade_sequencer;

    localparam int BW     = 9;
    localparam int No_SOS = 4;
    localparam int SMax   = (1 << (BW - 1)) - 1;
    localparam int SMin   = -(1 << (BW - 1));

    logic                 CLK = 1'b0;
    logic                 RESET = 1'b0;
    logic signed [BW-1:0] x_in = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [BW-1:0] stage_in;
    logic [3:0]           stage_idx;
    logic                 stage_en;
    logic signed [BW+1:0] stage_out;
    logic signed [BW-1:0] y_out;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic                 sat_flag;

    int n_checks = 0;
    int n_errors = 0;
    int offset   = 0;

    // Bench datapath: each pass adds a constant offset.
    assign stage_out = (BW+2)'(int'(stage_in) + offset);

    always #5 CLK = ~CLK;

    sos_cascade_sequencer #(.BW(BW), .No_SOS(No_SOS)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .x_in      (x_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .stage_in  (stage_in),
        .stage_idx (stage_idx),
        .stage_en  (stage_en),
        .stage_out (stage_out),
        .y_out     (y_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_flag  (sat_flag)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int v, inout bit ov);
        if (v > SMax) begin ov = 1'b1; return SMax; end
        if (v < SMin) begin ov = 1'b1; return SMin; end
        return v;
    endfunction

    function automatic void ref_filter(input int x, input int off, output int y, output bit s);
        int v = x;
        s = 1'b0;
        for (int i = 0; i < No_SOS; i++) v = clamp(v + off, s);
        y = v;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_in_ready"}, int'(in_ready), 1);
        check_eq({tag, "_out_valid"}, int'(out_valid), 0);
        check_eq({tag, "_stage_en"}, int'(stage_en), 0);
        check_eq({tag, "_y_out"}, int'(y_out), 0);
        check_eq({tag, "_stage_in"}, int'(stage_in), 0);
        check_eq({tag, "_stage_idx"}, int'(stage_idx), 0);
        check_eq({tag, "_sat_flag"}, int'(sat_flag), 0);
    endtask

    // One sample through the cascade; hold = cycles of backpressure after out_valid.
    task automatic send(input int x, input int off, input int hold);
        int  v;
        int  y_exp;
        bit  s;
        bit  s_exp;
        @(negedge CLK);
        offset    = off;
        x_in      = BW'(x);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        check_eq("pre_in_ready", int'(in_ready), 1);
        ref_filter(x, off, y_exp, s_exp);
        @(negedge CLK);
        in_valid = 1'b0;
        x_in     = BW'($urandom_range(0, 511));
        v = x;
        s = 1'b0;
        for (int i = 0; i < No_SOS; i++) begin
            check_eq("run_stage_en", int'(stage_en), 1);
            check_eq("run_stage_idx", int'(stage_idx), i);
            check_eq("run_stage_in", int'(stage_in), v);
            check_eq("run_in_ready", int'(in_ready), 0);
            check_eq("run_out_valid", int'(out_valid), 0);
            v = clamp(v + off, s);
            @(negedge CLK);
        end
        check_eq("done_out_valid", int'(out_valid), 1);
        check_eq("done_y_out", int'(y_out), y_exp);
        check_eq("done_sat_flag", int'(sat_flag), int'(s_exp));
        check_eq("done_stage_en", int'(stage_en), 0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            x_in     = BW'(99);
            @(negedge CLK);
            check_eq("hold_out_valid", int'(out_valid), 1);
            check_eq("hold_y_out", int'(y_out), y_exp);
            check_eq("hold_in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        check_eq("post_out_valid", int'(out_valid), 0);
        check_eq("post_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        int accepts;
        int last_acc;
        int outs;
        int exp_q[$];

        repeat (2) @(negedge CLK);
        check_idle_outputs("reset");
        RESET = 1'b1;

        // Reset on the second RUN cycle drops the sample.
        @(negedge CLK);
        offset   = 10;
        x_in     = BW'(50);
        in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        check_idle_outputs("midrun_rst");
        for (int i = 0; i < No_SOS + 3; i++) begin
            @(negedge CLK);
            check_eq("midrun_no_valid", int'(out_valid), 0);
        end

        send(5, 10, 0);
        send(200, 100, 0);
        send(-200, -100, 0);
        send(7, 0, 0);
        send(-17, 3, 10);
        send(99, 1, 0);

        for (int n = 0; n < 25; n++) begin
            send(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 1536)) - 768,
                 int'($urandom_range(0, 3)));
        end

        // Back-to-back throughput with out_ready tied high.
        @(negedge CLK);
        offset    = int'($urandom_range(0, 40)) - 20;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        x_in      = BW'($urandom_range(0, 511));
        accepts   = 0;
        outs      = 0;
        last_acc  = 0;
        for (int c = 0; c < 40; c++) begin
            int  y;
            bit  s;
            if (accepts == 3) in_valid = 1'b0;
            if (out_valid) begin
                outs++;
                if (exp_q.size() > 0) check_eq("tput_y_out", int'(y_out), exp_q.pop_front());
                else check_eq("tput_extra_output", 1, 0);
            end
            if (in_ready && in_valid) begin
                if (accepts > 0) check_eq("tput_gap", c - last_acc, No_SOS + 2);
                last_acc = c;
                accepts++;
                ref_filter(int'(x_in), offset, y, s);
                exp_q.push_back(y);
            end else begin
                x_in = BW'($urandom_range(0, 511));
            end
            @(negedge CLK);
        end
        check_eq("tput_accepts", accepts, 3);
        check_eq("tput_outputs", outs, 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sos_cascade_sequencer.md
# sos_cascade_sequencer

Front-end/back-end controller for the time-multiplexed second-order-section (SOS) cascade. Accepts one input sample through a valid/ready handshake and pushes it through `No_SOS` passes of the shared biquad datapath. On each pass it feeds the previous stage's saturated result back in and drives the stage index and enable used by the per-stage state memory. It then presents the final filtered sample through a valid/ready output handshake.

## Interface
- `BW`, default 9: signed sample width.
- `No_SOS`, default 4: number of cascaded sections. Legal range 1..15.
- `CLK`  input  1  system clock; all state changes on rising edge.
- `RESET`  input  1  synchronous, active-low reset.
- `x_in`  input  BW  signed input sample.
- `in_valid`  input  1  `x_in` valid.
- `in_ready`  output  1  sequencer can accept a sample.
- `stage_in`  output  BW  signed operand to the shared biquad datapath.
- `stage_idx`  output  4  section currently being computed (0..No_SOS-1).
- `stage_en`  output  1  high while a section is being computed; gates per-stage state-memory writes.
- `stage_out`  input  BW+2  signed datapath result for `stage_in`. Combinational in the same cycle.
- `y_out`  output  BW  signed filtered sample.
- `out_valid`  output  1  `y_out` valid.
- `out_ready`  input  1  downstream accepts `y_out`.
- `sat_flag`  output  1  saturation occurred on any pass of the current sample; valid with `out_valid`.

## Operation
- Registers:
  - `state` ∈ {IDLE, RUN, DONE}
  - `acc` [BW-1:0]
  - `idx` [3:0]
  - `sat` [0:0]
- Output assignments:
  - `stage_in` = `acc`
  - `y_out` = `acc`
  - `stage_idx` = `idx`
  - `sat_flag` = `sat`
  - `in_ready` = (`state` == IDLE)
  - `stage_en` = (`state` == RUN)
  - `out_valid` = (`state` == DONE)
- IDLE: on `in_valid` && `in_ready`, load `acc` <= `x_in`, `idx` <= 0, `sat` <= 0, go to RUN. Otherwise hold.
- RUN, every cycle:
  - `acc` <= sat(`stage_out`).
  - `sat` <= `sat` | overflow.
  - If `idx` == No_SOS-1: `idx` <= 0, go to DONE. Else `idx` <= `idx`+1.
- DONE: hold `acc` and `sat`. On `out_ready`, go to IDLE. `in_valid` is ignored in DONE.
- Saturation to BW bits:
  - `stage_out` > 2^(BW-1)-1 gives 2^(BW-1)-1 (255 at BW=9).
  - `stage_out` < -2^(BW-1) gives -2^(BW-1) (-256).
  - Otherwise the value is truncated to its low BW bits, which is exact in range.
  - overflow = either clamp taken.
- `x_in` is sampled only on the accept edge. Later changes to `x_in` have no effect on the sample in flight.
- `stage_out` is used only while in RUN. Its value in other states is don't-care.

## Timing
- Reset (`RESET`=0 at an edge), output values:
  - `state`=IDLE
  - `acc`=0, `idx`=0, `sat`=0
  - `in_ready`=1, `stage_en`=0, `out_valid`=0
  - `y_out`=0, `stage_in`=0, `stage_idx`=0, `sat_flag`=0
- Reset mid-RUN or mid-DONE drops the sample in flight. No `out_valid` pulse is produced for it.
- Edge sequence for one sample, with accept on edge E0:
  - `stage_en`=1 for exactly No_SOS cycles, between E0 and E_No_SOS.
  - `stage_idx` steps 0,1,…,No_SOS-1, one per cycle.
  - `out_valid` rises after E_No_SOS.
- Latency from accept edge to `out_valid` = No_SOS cycles.
- `out_valid` and `y_out` are held stable until an edge with `out_ready`=1. `in_ready` returns one cycle later.
- Minimum sample period = No_SOS+2 cycles, reached with `out_ready` tied high.
- `out_ready` arriving before `out_valid` has no effect.
- No_SOS=1: a single RUN cycle with `stage_idx`=0.

## Test plan
- Reset mid-RUN: accept 50, deassert `RESET` on the 2nd RUN cycle, then release. Expect `out_valid` to stay 0, all outputs 0, `in_ready`=1.
- Basic pass: BW=9, No_SOS=4, bench datapath `stage_out`=`stage_in`+10, `x_in`=5, `out_ready`=1.
  - `stage_in` sequence 5,15,25,35 with `stage_idx` 0..3 and `stage_en` high for 4 cycles.
  - `y_out`=45 with `out_valid` 4 cycles after accept.
  - `sat_flag`=0.
- Positive saturation: datapath +100, `x_in`=200. Expect pass results 255,255,255,255; `y_out`=255, `sat_flag`=1.
- Negative saturation and flag clear:
  - Datapath -100, `x_in`=-200. Expect `y_out`=-256, `sat_flag`=1.
  - Then datapath +0, `x_in`=7. Expect `y_out`=7, `sat_flag`=0.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid`.
  - `y_out` stable, `in_ready`=0, and `in_valid` with `x_in`=99 is not accepted.
  - After `out_ready`=1 for one edge, `in_ready`=1 and the next accept takes the current `x_in`.
- Back-to-back throughput: `in_valid` and `out_ready` held high over 3 samples. Expect accepts exactly 6 cycles apart, with outputs in input order.
